// File: rtl/traffic_light_multi.sv
// Highway / multi-side-road intersection controller with round-robin side grants
// and a night flash mode. Lamps are Moore outputs decoded from the registered state.
module traffic_light_multi #(
  parameter int NUM_SIDE     = 2,
  parameter int HW_MIN_GREEN = 10,
  parameter int YELLOW       = 3,
  parameter int ALL_RED      = 1,
  parameter int SIDE_GREEN   = 5,
  parameter int FLASH_HALF   = 2,
  localparam int SW = (NUM_SIDE > 1) ? $clog2(NUM_SIDE) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SIDE-1:0]   sensor,
  input  logic                  flash,
  output logic [2:0]            light_highway,
  output logic [3*NUM_SIDE-1:0] light_side,
  output logic [SW-1:0]         side_sel
);

  localparam logic [2:0] S_HW_GREEN   = 3'd0;
  localparam logic [2:0] S_HW_YELLOW  = 3'd1;
  localparam logic [2:0] S_ALL_RED_1  = 3'd2;
  localparam logic [2:0] S_SIDE_GREEN = 3'd3;
  localparam logic [2:0] S_SIDE_YEL   = 3'd4;
  localparam logic [2:0] S_ALL_RED_2  = 3'd5;
  localparam logic [2:0] S_FLASH      = 3'd6;

  localparam int M1   = (HW_MIN_GREEN > SIDE_GREEN) ? HW_MIN_GREEN : SIDE_GREEN;
  localparam int M2   = (YELLOW > ALL_RED) ? YELLOW : ALL_RED;
  localparam int MAXD = (M1 > M2) ? M1 : M2;
  localparam int TW   = $clog2(MAXD) + 1;
  localparam int BW   = $clog2(FLASH_HALF) + 1;

  localparam logic [TW-1:0] T_HWG = TW'(HW_MIN_GREEN - 1);
  localparam logic [TW-1:0] T_YEL = TW'(YELLOW - 1);
  localparam logic [TW-1:0] T_AR  = TW'(ALL_RED - 1);
  localparam logic [TW-1:0] T_SG  = TW'(SIDE_GREEN - 1);
  localparam logic [BW-1:0] B_END = BW'(FLASH_HALF - 1);

  logic [2:0]            state, nxt;
  logic [TW-1:0]         timer;
  logic [BW-1:0]         blink_cnt;
  logic                  blink_off;
  logic                  flash_exit;
  logic [NUM_SIDE-1:0]   pending, pend_nxt, req, sel_mask, rot;
  logic [2*NUM_SIDE-1:0] dbl;
  logic [SW:0]           base, cand;
  logic [SW-1:0]         last, grant;
  logic                  side_enter;

  assign req        = pending | sensor;
  assign sel_mask   = NUM_SIDE'(1) << side_sel;
  assign side_enter = (state == S_ALL_RED_1) && (nxt == S_SIDE_GREEN);

  always_comb begin
    nxt = state;
    case (state)
      S_HW_GREEN:   if (flash || ((timer >= T_HWG) && (|req))) nxt = S_HW_YELLOW;
      S_HW_YELLOW:  if (timer == T_YEL) nxt = S_ALL_RED_1;
      S_ALL_RED_1:  if (timer == T_AR)  nxt = flash_exit ? S_FLASH : S_SIDE_GREEN;
      S_SIDE_GREEN: if (timer == T_SG)  nxt = S_SIDE_YEL;
      S_SIDE_YEL:   if (timer == T_YEL) nxt = S_ALL_RED_2;
      S_ALL_RED_2:  if (timer == T_AR)  nxt = S_HW_GREEN;
      S_FLASH:      if (!flash)         nxt = S_ALL_RED_2;
      default:      nxt = S_HW_GREEN;
    endcase
  end

  // Round-robin: rotate req so bit 0 is side last+1, then take the lowest set bit.
  always_comb begin
    base  = {1'b0, last} + (SW+1)'(1);
    dbl   = {req, req} >> base;
    rot   = dbl[NUM_SIDE-1:0];
    grant = side_sel;
    cand  = '0;
    for (int k = NUM_SIDE - 1; k >= 0; k--) begin
      if (rot[k]) begin
        cand = base + (SW+1)'(k);
        if (cand >= (SW+1)'(NUM_SIDE)) cand = cand - (SW+1)'(NUM_SIDE);
        grant = cand[SW-1:0];
      end
    end
  end

  // The side being served ignores its own sensor; its latch clears on green entry.
  always_comb begin
    pend_nxt = pending | sensor;
    if ((state == S_SIDE_GREEN) || (state == S_SIDE_YEL))
      pend_nxt = pending | (sensor & ~sel_mask);
    if (side_enter) pend_nxt = pend_nxt & ~sel_mask;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_HW_GREEN;
      timer      <= '0;
      pending    <= '0;
      last       <= SW'(NUM_SIDE - 1);
      side_sel   <= '0;
      flash_exit <= 1'b0;
      blink_cnt  <= '0;
      blink_off  <= 1'b0;
    end else begin
      state   <= nxt;
      pending <= pend_nxt;
      if (nxt != state)     timer <= '0;
      else if (timer != '1) timer <= timer + TW'(1);
      if ((state == S_HW_GREEN) && (nxt == S_HW_YELLOW)) begin
        flash_exit <= flash;
        if (!flash) side_sel <= grant;
      end
      if (side_enter) last <= side_sel;
      if (state != S_FLASH) begin
        blink_cnt <= '0;
        blink_off <= 1'b0;
      end else if (blink_cnt == B_END) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

  always_comb begin
    case (state)
      S_HW_GREEN:  light_highway = 3'b001;
      S_HW_YELLOW: light_highway = 3'b010;
      S_FLASH:     light_highway = blink_off ? 3'b000 : 3'b010;
      default:     light_highway = 3'b100;
    endcase
    light_side = {NUM_SIDE{3'b100}};
    for (int i = 0; i < NUM_SIDE; i++) begin
      if (sel_mask[i] && (state == S_SIDE_GREEN)) light_side[3*i +: 3] = 3'b001;
      if (sel_mask[i] && (state == S_SIDE_YEL))   light_side[3*i +: 3] = 3'b010;
    end
  end

endmodule

// File: doc/traffic_light_multi.md
TRAFFIC_LIGHT_MULTI -- requirements
Module: traffic_light_multi

Interface
REQ-001 Parameter NUM_SIDE, default 2, number of side-road approaches; legal range 1..8.
REQ-002 Parameter HW_MIN_GREEN, default 10, minimum highway green in cycles; must be >= 1.
REQ-003 Parameter YELLOW, default 3, yellow duration in cycles for any road; must be >= 1.
REQ-004 Parameter ALL_RED, default 1, all-red clearance in cycles; must be >= 1.
REQ-005 Parameter SIDE_GREEN, default 5, side-road green in cycles; must be >= 1.
REQ-006 Parameter FLASH_HALF, default 2, half-period of flash blink in cycles; must be >= 1.
REQ-007 clk  input  1  single clock; all state changes on rising edge.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 sensor  input  NUM_SIDE  bit i high = vehicle waiting on side road i.
REQ-010 flash  input  1  high = request night flash mode.
REQ-011 light_highway  output  3  {R,Y,G}: red 100, yellow 010, green 001, off 000.
REQ-012 light_side  output  3*NUM_SIDE  bits [3i+2:3i] = side road i, same encoding.
REQ-013 side_sel  output  ceil(log2(NUM_SIDE)) (min 1)  index of side currently granted/being served.

Function
REQ-014 States: HW_GREEN, HW_YELLOW, ALL_RED_1, SIDE_GREEN, SIDE_YELLOW, ALL_RED_2, FLASH; Moore outputs decoded from registered state.
REQ-015 Cycle timer resets to 0 on every state transition, increments each cycle otherwise; timed state of duration D occupies exactly D cycles.
REQ-016 Request latch pending[i] sets on any cycle sensor[i]=1; holds until side i enters SIDE_GREEN, where it clears (clear wins); sensor[sel] ignored while in SIDE_GREEN/SIDE_YELLOW.
REQ-017 req = pending | sensor; a one-cycle sensor pulse is never lost.
REQ-018 HW_GREEN -> HW_YELLOW when (timer >= HW_MIN_GREEN-1 and any req bit set) or flash=1 (flash waives minimum green).
REQ-019 Grant at HW_GREEN exit: first set req bit searching last+1, last+2, ... modulo NUM_SIDE; latched into side_sel; last updated to side_sel on SIDE_GREEN entry.
REQ-020 HW_YELLOW -> ALL_RED_1 after YELLOW cycles.
REQ-021 ALL_RED_1 -> FLASH after ALL_RED cycles if exit was flash-caused (flash had priority), else -> SIDE_GREEN.
REQ-022 SIDE_GREEN -> SIDE_YELLOW after SIDE_GREEN cycles; SIDE_YELLOW -> ALL_RED_2 after YELLOW cycles; ALL_RED_2 -> HW_GREEN after ALL_RED cycles.
REQ-023 Side phase always completes and returns to HW_GREEN even with flash or other requests pending; highway always regains a green between side services.
REQ-024 FLASH: all sides 100; highway 010 for FLASH_HALF cycles, then 000 for FLASH_HALF, repeating, starting 010 on entry.
REQ-025 FLASH exits when flash=0 to ALL_RED_2 (ALL_RED cycles) then HW_GREEN with fresh timer; pending continues latching during FLASH.
REQ-026 Outputs per state: HW_GREEN hw 001; HW_YELLOW hw 010; ALL_RED_x hw 100; side states hw 100; side side_sel shows 001/010 in SIDE_GREEN/SIDE_YELLOW, every other side 100 in all non-FLASH states.
REQ-027 Never two roads non-red simultaneously; never green directly to red without yellow.

Reset
REQ-028 rst_n=0 at a rising edge: state HW_GREEN, timer 0, pending 0, last NUM_SIDE-1, side_sel 0; next cycle light_highway=001, all light_side=100.
REQ-029 Reset mid-operation (any state, incl. FLASH) takes effect at the next edge and overrides all transitions and latch updates.

Verification (defaults)
REQ-030 Reset, sensor=0, flash=0 for 50 cycles -> light_highway=001, light_side=100100 every cycle.
REQ-031 sensor[0] held from cycle 2 after reset release (cycle 0 = first HW_GREEN) -> hw green 0-9, yellow 10-12, all-red 13, side0 green 14-18, yellow 19-21, all-red 22, hw green from 23.
REQ-032 sensor=11 pulsed one cycle at cycle 3 -> side0 served cycles 14-21; hw green 23-32; side1 green 37-41; side_sel=1.
REQ-033 flash raised during side1 green -> side1 completes, hw green exactly 1 cycle, yellow 3, all-red 1, then hw 010,010,000,000,... sides 100.
REQ-034 flash dropped in FLASH -> 1 cycle all-red, then hw green holds >= 10 cycles despite pending requests.
REQ-035 rst_n=0 one cycle during side0 green with sensor[1] pending -> next cycle hw 001, pending cleared, no side served without new sensor.
